// File: rtl/dmem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_pkg : shared types and helpers for the dmem_strobe data memory
// Rev 1.0
// ----------------------------------------------------------------------------
package dmem_pkg;

  localparam int unsigned c_max_data_width = 64;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // rdata is sized for the widest configuration; narrower words zero-extend
  typedef struct packed {
    logic                        valid;
    logic                        err;
    logic [c_max_data_width-1:0] rdata;
  } rsp_t;

  function automatic logic is_aligned(input logic [31:0] addr, input int unsigned bytes);
    logic [31:0] mask;
    mask = bytes - 1;
    return (addr & mask) == 32'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_rsp_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_rsp_pipe : fixed-depth response shift register with valid-only reset
// Rev 1.0
// ----------------------------------------------------------------------------
module dmem_rsp_pipe
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  rsp_t                  rsp_in,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  rsp_t r_stage [DEPTH];
  logic w_unused_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i].valid <= 1'b0;
      end
    end else begin
      r_stage[0] <= rsp_in;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  // Payload is only trusted while valid; gating keeps idle outputs at zero
  assign rsp_valid      = r_stage[DEPTH-1].valid;
  assign rsp_rdata      = rsp_valid ? r_stage[DEPTH-1].rdata[DATA_WIDTH-1:0] : '0;
  assign rsp_err        = rsp_valid & r_stage[DEPTH-1].err;
  assign w_unused_rdata = ^r_stage[DEPTH-1].rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_strobe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_strobe : byte-strobed data memory with valid/ready requests,
//               post-reset clear sweep and fixed-latency responses
// Rev 1.0
// ----------------------------------------------------------------------------
module dmem_strobe
  import dmem_pkg::*;
#(
  parameter int    WORDS        = 64,
  parameter int    DATA_WIDTH   = 32,
  parameter int    READ_LATENCY = 1,
  parameter string MEM_INIT     = ""
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [31:0]             req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err
);

  localparam int c_bytes      = DATA_WIDTH / 8;
  localparam int c_off_bits   = $clog2(c_bytes);
  localparam int c_idx_bits   = $clog2(WORDS);
  localparam bit c_skip_clear = (MEM_INIT != "");
  localparam logic [c_idx_bits-1:0] c_last_idx = c_idx_bits'(WORDS - 1);

  state_t                r_state;
  logic                  r_ready;
  logic [c_idx_bits-1:0] r_clr_cnt;
  logic [DATA_WIDTH-1:0] r_mem [WORDS];

  logic                  w_accept;
  logic                  w_misaligned;
  logic                  w_out_of_range;
  logic                  w_err;
  logic                  w_wr_en;
  logic [c_idx_bits-1:0] w_idx;
  rsp_t                  w_rsp;

  assign req_ready      = r_ready;
  assign w_accept       = req_valid & r_ready;
  assign w_idx          = req_addr[c_off_bits +: c_idx_bits];
  assign w_misaligned   = !is_aligned(req_addr, c_bytes);
  // Any address bit above the index field means the word lies beyond the array
  assign w_out_of_range = |(req_addr >> (c_off_bits + c_idx_bits));
  assign w_err          = w_misaligned | w_out_of_range;
  assign w_wr_en        = w_accept & req_write & ~w_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= c_skip_clear ? READY : CLEAR;
      r_ready   <= 1'b0;
      r_clr_cnt <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_clr_cnt <= r_clr_cnt + c_idx_bits'(1);
          if (r_clr_cnt == c_last_idx) begin
            r_state <= READY;
            r_ready <= 1'b1;
          end
        end
        READY: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= CLEAR;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Array is not reset; writes are suppressed on any edge where rst_n is low
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == CLEAR) begin
        r_mem[r_clr_cnt] <= '0;
      end else if (w_wr_en) begin
        for (int b = 0; b < c_bytes; b++) begin
          if (req_wstrb[b]) begin
            r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    w_rsp       = '0;
    w_rsp.valid = w_accept;
    w_rsp.err   = w_accept & w_err;
    if (w_accept && !req_write && !w_err) begin
      w_rsp.rdata[DATA_WIDTH-1:0] = r_mem[w_idx];
    end
  end

  dmem_rsp_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (READ_LATENCY)
  ) u_rsp_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .rsp_in    (w_rsp),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

endmodule
`default_nettype wire

// File: tb/tb_dmem_strobe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dmem_strobe : scoreboard bench for dmem_strobe (64 x 32b, latency 3)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_dmem_strobe;

  localparam int WORDS = 64;
  localparam int LAT   = 3;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr  = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_wstrb = 4'd0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_strobe #(
    .WORDS        (WORDS),
    .DATA_WIDTH   (32),
    .READ_LATENCY (LAT),
    .MEM_INIT     ("")
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] model [WORDS];
  int          n_cmp  = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (rsp_valid) begin
        check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
          check("rsp_latency", 64'(cyc - e.acc), 64'(LAT - 1));
        end
      end else begin
        check("idle_rdata", 64'(rsp_rdata), 64'd0);
        check("idle_err", 64'(rsp_err), 64'd0);
      end
    end
  end

  task automatic send(input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] ws);
    exp_t e;
    logic err;
    int   idx;
    @(negedge clk);
    check("req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = ws;
    err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(WORDS));
    idx = int'(addr[7:2]);
    if (wr && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (ws[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
    e.rdata = (!wr && !err) ? model[idx] : 32'd0;
    e.err   = err;
    e.acc   = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    req_valid = 1'b0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic reset_and_sweep();
    int cnt = 0;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    exp_q.delete();
    for (int i = 0; i < WORDS; i++) model[i] = 32'd0;
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    while (!req_ready && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check("ready_low_cycles", 64'(cnt), 64'd64);
  endtask

  initial begin : stim
    logic [31:0] addr;
    reset_and_sweep();

    for (int i = 0; i < WORDS; i++) send(1'b0, 32'(i * 4), 32'd0, 4'h0);
    drain();

    send(1'b1, 32'h10, 32'hAABBCCDD, 4'hF);
    send(1'b1, 32'h10, 32'h11223344, 4'b0101);
    send(1'b0, 32'h10, 32'd0, 4'h0);
    drain();

    send(1'b1, 32'h0, 32'h01020304, 4'hF);
    send(1'b1, 32'h4, 32'h05060708, 4'hF);
    send(1'b1, 32'h8, 32'h090A0B0C, 4'hF);
    drain();
    send(1'b0, 32'h0, 32'd0, 4'h0);
    send(1'b0, 32'h4, 32'd0, 4'h0);
    send(1'b0, 32'h8, 32'd0, 4'h0);
    drain();

    send(1'b1, 32'h6, 32'hDEADBEEF, 4'hF);
    send(1'b0, 32'h100, 32'd0, 4'h0);
    send(1'b0, 32'h4, 32'd0, 4'h0);
    send(1'b0, 32'h0, 32'd0, 4'h0);
    drain();

    send(1'b1, 32'h0, 32'hCAFEF00D, 4'hF);
    send(1'b0, 32'h0, 32'd0, 4'h0);
    send(1'b1, 32'h0, 32'h12345678, 4'h0);
    send(1'b0, 32'h0, 32'd0, 4'h0);
    send(1'b1, 32'hFC, 32'h87654321, 4'b1010);
    send(1'b0, 32'hFC, 32'd0, 4'h0);
    send(1'b0, 32'hFFFF_FFFC, 32'd0, 4'h0);
    send(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF);
    send(1'b0, 32'h0, 32'd0, 4'h0);
    drain();

    for (int i = 0; i < 40; i++) begin
      addr = 32'($urandom_range(0, 70)) << 2;
      if ($urandom_range(0, 9) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      send(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)));
    end
    drain();

    send(1'b1, 32'h20, 32'h55AA55AA, 4'hF);
    drain();
    send(1'b0, 32'h20, 32'd0, 4'h0);
    send(1'b0, 32'h20, 32'd0, 4'h0);
    reset_and_sweep();
    send(1'b0, 32'h20, 32'd0, 4'h0);
    send(1'b0, 32'h10, 32'd0, 4'h0);
    send(1'b0, 32'h0, 32'd0, 4'h0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
